fa_resp_checker: RTL and testbench

//  Synthesizable self-checking monitor for the 1-bit full adder.
//  - Observes the stimulus driven into the adder (a, b, c_in) and the adder's response (s, c_out).
//  - Compares the response against the golden model, counts mismatches and records truth-table coverage.
//  - Flags pass/fail once a test window completes.
//  - Sits beside the adder in on-chip/FPGA self-test; the receiving end of the adder's stimulus path.

---
 rtl/fa_resp_checker_if.sv | 33 +++
 rtl/fa_resp_checker.sv | 132 +++++++++++++
 tb/tb_fa_resp_checker.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/fa_resp_checker_if.sv
// Stimulus/response/result bundle between a full-adder self-test driver and its checker.
// No storage: plain wires, the checker registers everything it drives.
// No backpressure: the checker accepts one sample per cycle whenever vld is high.
interface fa_resp_checker_if #(
   parameter int ERR_W = 8
);
   logic             start;
   logic             vld;
   logic             a;
   logic             b;
   logic             c_in;
   logic             s;
   logic             c_out;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic [7:0]       cov;
   logic             first_err_vld;
   logic [4:0]       first_err_vec;

   // Driver side: supplies stimulus and the adder response, reads results.
   modport master (
      output start, vld, a, b, c_in, s, c_out,
      input  busy, done, pass, err_cnt, cov, first_err_vld, first_err_vec
   );

   // Checker side.
   modport slave (
      input  start, vld, a, b, c_in, s, c_out,
      output busy, done, pass, err_cnt, cov, first_err_vld, first_err_vec
   );
endinterface

// File: rtl/fa_resp_checker.sv
// Self-checking monitor for a 1-bit full adder: compares responses, counts errors, tracks vector coverage.
// Latency: stimulus delayed LAT cycles to meet the response; results registered one cycle after the compare.
// Backpressure: none; one sample per cycle, vld outside a running window is ignored.
module fa_resp_checker #(
   parameter int LAT     = 0,
   parameter int MAX_SMP = 16,
   parameter int ERR_W   = 8
) (
   input logic               clk,
   input logic               rst_n,
   fa_resp_checker_if.slave  bus
);
   localparam int SMP_W = 16;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [SMP_W-1:0] smp_q, smp_d;
   logic [ERR_W-1:0] err_q, err_d;
   logic [7:0]       cov_q, cov_d;
   logic             fv_q, fv_d;
   logic [4:0]       fvec_q, fvec_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             pass_q, pass_d;

   // Stimulus as seen at the end of the alignment pipe.
   logic             d_vld;
   logic [2:0]       d_vec;

   generate
      if (LAT == 0) begin : g_nopipe
         assign d_vld = bus.vld;
         assign d_vec = {bus.a, bus.b, bus.c_in};
      end else begin : g_pipe
         logic [LAT-1:0] pv;
         logic [2:0]     pd [LAT];

         // Delay line; start flushes every valid bit so older and start-cycle samples never get checked.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               pv <= '0;
               for (int i = 0; i < LAT; i++) pd[i] <= '0;
            end else begin
               pv[0] <= bus.start ? 1'b0 : bus.vld;
               pd[0] <= {bus.a, bus.b, bus.c_in};
               for (int i = 1; i < LAT; i++) begin
                  pv[i] <= bus.start ? 1'b0 : pv[i-1];
                  pd[i] <= pd[i-1];
               end
            end
         end

         assign d_vld = pv[LAT-1];
         assign d_vec = pd[LAT-1];
      end
   endgenerate

   // Golden full adder and the per-cycle compare qualifier.
   logic       exp_s, exp_c, mis, chk, last;
   assign exp_s = d_vec[2] ^ d_vec[1] ^ d_vec[0];
   assign exp_c = (d_vec[2] & d_vec[1]) | (d_vec[2] & d_vec[0]) | (d_vec[1] & d_vec[0]);
   // Case inequality so an X/Z response is counted as a mismatch in simulation.
   assign mis   = ({bus.c_out, bus.s} !== {exp_c, exp_s});
   assign chk   = (state_q == RUN) && !bus.start && d_vld;
   assign last  = (smp_q == SMP_W'(MAX_SMP - 1));

   // Next-state and next-result logic; start wins over any sample in the same cycle.
   always_comb begin
      state_d = state_q;
      smp_d   = smp_q;
      err_d   = err_q;
      cov_d   = cov_q;
      fv_d    = fv_q;
      fvec_d  = fvec_q;
      if (bus.start) begin
         state_d = RUN;
         smp_d   = '0;
         err_d   = '0;
         cov_d   = '0;
         fv_d    = 1'b0;
         fvec_d  = '0;
      end else if (chk) begin
         cov_d[d_vec] = 1'b1;
         smp_d        = smp_q + SMP_W'(1);
         if (mis) begin
            if (err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);
            if (!fv_q) begin
               fv_d   = 1'b1;
               fvec_d = {d_vec, bus.c_out, bus.s};
            end
         end
         if (last) state_d = DONE;
      end
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
      pass_d = done_d && (err_d == '0) && (cov_d == 8'hFF);
   end

   // State and result registers; all outputs come straight from here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         smp_q   <= '0;
         err_q   <= '0;
         cov_q   <= '0;
         fv_q    <= 1'b0;
         fvec_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         smp_q   <= smp_d;
         err_q   <= err_d;
         cov_q   <= cov_d;
         fv_q    <= fv_d;
         fvec_q  <= fvec_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.pass          = pass_q;
   assign bus.err_cnt       = err_q;
   assign bus.cov           = cov_q;
   assign bus.first_err_vld = fv_q;
   assign bus.first_err_vec = fvec_q;
endmodule

// File: tb/tb_fa_resp_checker.sv
// Bench for fa_resp_checker: three checker configurations fed the same stimulus, each beside its own adder model.
// Every cycle all outputs are compared with results recomputed from the logged stimulus/response history.
// Adder models: correct, s stuck-at-0, inverted s, 2-cycle delayed, delayed with bad carry, random.
module tb_fa_resp_checker;
   localparam int NCYC = 1024;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fa_resp_checker_if #(.ERR_W(8)) if_a ();
   fa_resp_checker_if #(.ERR_W(8)) if_b ();
   fa_resp_checker_if #(.ERR_W(2)) if_c ();

   // A: LAT=0, 8-sample window. B: LAT=2, 8-sample window. C: LAT=0, 4-sample window, 2-bit error counter.
   fa_resp_checker #(.LAT(0), .MAX_SMP(8), .ERR_W(8)) u_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
   fa_resp_checker #(.LAT(2), .MAX_SMP(8), .ERR_W(8)) u_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
   fa_resp_checker #(.LAT(0), .MAX_SMP(4), .ERR_W(2)) u_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

   // Per-cycle history of what was driven.
   logic       st_h  [NCYC];
   logic       v_h   [NCYC];
   logic [2:0] vec_h [NCYC];
   logic [1:0] rsp_h [3][NCYC];

   int cyc      = 0;
   int log_base = 0;
   int tests    = 0;
   int failed   = 0;
   int mode [3];

   // Reference adder result {c_out,s} as the arithmetic sum of the three input bits.
   function automatic logic [1:0] gold(input logic [2:0] v);
      logic [1:0] sum;
      sum = {1'b0, v[2]} + {1'b0, v[1]} + {1'b0, v[0]};
      return sum;
   endfunction

   // Adder under test as seen by instance k in cycle t.
   function automatic logic [1:0] adder(input int m, input int t);
      logic [2:0] old;
      old = (t >= 2) ? vec_h[t-2] : 3'b000;
      case (m)
         0:       return gold(vec_h[t]);
         1:       return gold(vec_h[t]) & 2'b10;
         2:       return gold(vec_h[t]) ^ 2'b01;
         3:       return gold(old);
         4:       return gold(old) ^ 2'b10;
         default: return 2'($urandom_range(0, 3));
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         failed++;
         $error("FAIL %s @cycle %0d observed=%0h expected=%0h", tag, cyc, obs, expv);
      end
   endtask

   // Expected results for instance k after the edges of cycles 0..cyc-1, from the window opened by the last start.
   task automatic model(input int k, output int eb, output int ed, output int ep, output int ee,
                        output int ec, output int efv, output int efe);
      int ts, lat, mx, sat, cnt, mis;
      logic [1:0] r;
      lat = (k == 1) ? 2 : 0;
      mx  = (k == 2) ? 4 : 8;
      sat = (k == 2) ? 3 : 255;
      eb = 0; ed = 0; ep = 0; ee = 0; ec = 0; efv = 0; efe = 0;
      ts = -1;
      for (int t = log_base; t < cyc; t++) if (st_h[t]) ts = t;
      if (ts < 0) return;
      cnt = 0;
      mis = 0;
      for (int e = ts + 1; (e + lat <= cyc - 1) && (cnt < mx); e++) begin
         if (v_h[e]) begin
            r = rsp_h[k][e + lat];
            cnt++;
            ec = ec | (1 << vec_h[e]);
            if (r !== gold(vec_h[e])) begin
               mis++;
               if (efv == 0) begin
                  efv = 1;
                  efe = int'({vec_h[e], r});
               end
            end
         end
      end
      ee = (mis > sat) ? sat : mis;
      ed = (cnt >= mx) ? 1 : 0;
      eb = (cnt >= mx) ? 0 : 1;
      ep = (ed == 1 && ee == 0 && ec == 255) ? 1 : 0;
   endtask

   task automatic check_all();
      int eb, ed, ep, ee, ec, efv, efe;
      model(0, eb, ed, ep, ee, ec, efv, efe);
      chk("A.busy", 32'(if_a.busy), eb);       chk("A.done", 32'(if_a.done), ed);
      chk("A.pass", 32'(if_a.pass), ep);       chk("A.err_cnt", 32'(if_a.err_cnt), ee);
      chk("A.cov", 32'(if_a.cov), ec);         chk("A.first_err_vld", 32'(if_a.first_err_vld), efv);
      chk("A.first_err_vec", 32'(if_a.first_err_vec), efe);
      model(1, eb, ed, ep, ee, ec, efv, efe);
      chk("B.busy", 32'(if_b.busy), eb);       chk("B.done", 32'(if_b.done), ed);
      chk("B.pass", 32'(if_b.pass), ep);       chk("B.err_cnt", 32'(if_b.err_cnt), ee);
      chk("B.cov", 32'(if_b.cov), ec);         chk("B.first_err_vld", 32'(if_b.first_err_vld), efv);
      chk("B.first_err_vec", 32'(if_b.first_err_vec), efe);
      model(2, eb, ed, ep, ee, ec, efv, efe);
      chk("C.busy", 32'(if_c.busy), eb);       chk("C.done", 32'(if_c.done), ed);
      chk("C.pass", 32'(if_c.pass), ep);       chk("C.err_cnt", 32'(if_c.err_cnt), ee);
      chk("C.cov", 32'(if_c.cov), ec);         chk("C.first_err_vld", 32'(if_c.first_err_vld), efv);
      chk("C.first_err_vec", 32'(if_c.first_err_vec), efe);
   endtask

   // One clock cycle: log and drive inputs, take the edge, then compare everything.
   task automatic step(input logic st, input logic v, input logic [2:0] vec);
      st_h[cyc]  = st;
      v_h[cyc]   = v;
      vec_h[cyc] = vec;
      for (int k = 0; k < 3; k++) rsp_h[k][cyc] = adder(mode[k], cyc);
      if_a.start = st; if_a.vld = v; {if_a.a, if_a.b, if_a.c_in} = vec; {if_a.c_out, if_a.s} = rsp_h[0][cyc];
      if_b.start = st; if_b.vld = v; {if_b.a, if_b.b, if_b.c_in} = vec; {if_b.c_out, if_b.s} = rsp_h[1][cyc];
      if_c.start = st; if_c.vld = v; {if_c.a, if_c.b, if_c.c_in} = vec; {if_c.c_out, if_c.s} = rsp_h[2][cyc];
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic window(input int n, input int idle);
      step(1'b1, 1'b0, 3'b000);
      for (int v = 0; v < n; v++) step(1'b0, 1'b1, 3'(v));
      for (int i = 0; i < idle; i++) step(1'b0, 1'b0, 3'b000);
   endtask

   initial begin
      mode[0] = 0;
      mode[1] = 3;
      mode[2] = 0;

      // Reset, then vld while idle must be ignored.
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 3'b000);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 3'b101);
      step(1'b0, 1'b1, 3'b011);

      // Correct adders, all eight vectors: A and B pass, C sees only 000..011.
      window(8, 4);

      // A: s stuck-at-0 (4 errors, first at vector 001). C: inverted s, counter saturates.
      mode[0] = 1;
      mode[2] = 2;
      window(8, 4);

      // A fed a 2-cycle-late adder while expecting zero latency.
      mode[0] = 3;
      mode[2] = 0;
      step(1'b1, 1'b0, 3'b000);
      for (int i = 0; i < 14; i++) step(1'b0, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'b000);

      // Restart after three samples, then asynchronous reset mid-window.
      mode[0] = 1;
      window(3, 0);
      mode[0] = 0;
      window(8, 2);
      window(2, 0);
      rst_n = 1'b0;
      log_base = cyc;
      #1;
      check_all();
      step(1'b0, 1'b1, 3'b111);
      step(1'b0, 1'b1, 3'b110);
      rst_n = 1'b1;
      step(1'b0, 1'b1, 3'b001);

      // Random starts, gaps, vectors and adder faults.
      for (int i = 0; i < 300; i++) begin
         logic st;
         st = ($urandom_range(0, 14) == 0);
         if (st) begin
            mode[0] = $urandom_range(0, 5);
            mode[1] = $urandom_range(3, 5);
            mode[2] = $urandom_range(0, 5);
         end
         step(st, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
